vga_sync_decoder: RTL and testbench

Receive-side counterpart of the VGA timing generator. Samples an incoming h_sync/v_sync/RGB stream in the pixel clock domain, recovers line and frame timing, locks after consecutive good frames, and emits active-area pixel coordinates and colour. Used as a loopback checker and capture front end for the game display path.

---
 rtl/vga_timing_pkg.sv | 29 ++
 rtl/sync_edge_detect.sv | 27 ++
 rtl/vga_sync_decoder.sv | 178 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Timing constants shared with the VGA generator, decoder FSM states and a
// saturating counter helper.
package vga_timing_pkg;

    localparam int unsigned VGA_BH_TIME = 96;
    localparam int unsigned VGA_CH_TIME = 48;
    localparam int unsigned VGA_DH_TIME = 640;
    localparam int unsigned VGA_TOTAL_H = 800;
    localparam int unsigned VGA_BV_TIME = 2;
    localparam int unsigned VGA_CV_TIME = 33;
    localparam int unsigned VGA_DV_TIME = 480;
    localparam int unsigned VGA_TOTAL_V = 525;

    // Fixed encodings kept so state values match older captures/dumps.
    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    typedef enum logic [1:0] {
        SEARCH  = ST_SEARCH,
        MEASURE = ST_MEASURE,
        LOCKED  = ST_LOCKED
    } sync_state_e;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == '1) ? v : v + 11'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one active-low sync input and flags its 1->0 transition.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync_i,
    output logic level_o,
    output logic fall_o
);

    logic level_q;
    logic prev_q;

    // Idle level is high so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            level_q <= sync_i;
            prev_q  <= level_q;
        end
    end

    assign level_o = level_q;
    assign fall_o  = prev_q & ~level_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers line/frame timing from an incoming VGA stream, locks after
// consecutive good frames and emits active-area coordinates and colour.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int unsigned BH_TIME     = VGA_BH_TIME,
    parameter int unsigned CH_TIME     = VGA_CH_TIME,
    parameter int unsigned DH_TIME     = VGA_DH_TIME,
    parameter int unsigned TOTAL_H     = VGA_TOTAL_H,
    parameter int unsigned H_TOL       = 2,
    parameter int unsigned BV_TIME     = VGA_BV_TIME,
    parameter int unsigned CV_TIME     = VGA_CV_TIME,
    parameter int unsigned DV_TIME     = VGA_DV_TIME,
    parameter int unsigned TOTAL_V     = VGA_TOTAL_V,
    parameter int unsigned V_TOL       = 1,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic        sync_error
);

    localparam logic [10:0] H_ACT_LO = 11'(BH_TIME + CH_TIME);
    localparam logic [10:0] H_ACT_HI = 11'(BH_TIME + CH_TIME + DH_TIME - 1);
    localparam logic [10:0] V_ACT_LO = 11'(BV_TIME + CV_TIME);
    localparam logic [10:0] V_ACT_HI = 11'(BV_TIME + CV_TIME + DV_TIME - 1);
    localparam logic [10:0] H_MIN    = 11'(TOTAL_H - H_TOL);
    localparam logic [10:0] H_MAX    = 11'(TOTAL_H + H_TOL);
    localparam logic [10:0] V_MIN    = 11'(TOTAL_V - V_TOL);
    localparam logic [10:0] V_MAX    = 11'(TOTAL_V + V_TOL);
    localparam logic [7:0]  LOCK_CNT = 8'(LOCK_FRAMES);

    logic        hs_lvl, hs_fall, vs_lvl, vs_fall;
    logic        unused_levels;
    logic [23:0] rgb_q;

    logic [10:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d, h_meas, v_meas;
    logic        vs_pend_q, vs_pend_d, lines_bad_q, lines_bad_d;
    logic [7:0]  good_cnt_q, good_cnt_d;
    sync_state_e state_q, state_d;

    logic        line_edge, frame_apply, line_ok, frame_ok, h_missing;
    logic        in_window, valid_d, err_d;

    logic [10:0] pixel_x_q, pixel_y_q, line_len_q;
    logic [23:0] pixel_rgb_q;
    logic        pixel_valid_q, frame_start_q, locked_q, sync_error_q;

    sync_edge_detect u_hs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (h_sync),
        .level_o(hs_lvl),
        .fall_o (hs_fall)
    );

    sync_edge_detect u_vs_edge (
        .clk    (clk),
        .reset  (reset),
        .sync_i (v_sync),
        .level_o(vs_lvl),
        .fall_o (vs_fall)
    );

    assign unused_levels = hs_lvl ^ vs_lvl;

    // h_cnt_d/v_cnt_d are the coordinates of the pixel currently held in S1.
    always_comb begin
        h_meas      = sat_inc11(h_cnt_q);
        v_meas      = sat_inc11(v_cnt_q);
        line_edge   = hs_fall;
        frame_apply = line_edge && (vs_pend_q || vs_fall);
        h_cnt_d     = line_edge ? '0 : h_meas;
        v_cnt_d     = frame_apply ? '0 : (line_edge ? v_meas : v_cnt_q);
        vs_pend_d   = frame_apply ? 1'b0 : (vs_pend_q | vs_fall);
        line_ok     = (h_meas >= H_MIN) && (h_meas <= H_MAX);
        frame_ok    = !lines_bad_q && line_ok && (v_meas >= V_MIN) && (v_meas <= V_MAX);
        lines_bad_d = frame_apply ? 1'b0 : (lines_bad_q | (line_edge & ~line_ok));
        h_missing   = h_cnt_d > H_MAX;
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        err_d      = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (frame_apply) begin
                    state_d    = MEASURE;
                    good_cnt_d = '0;
                end
            end
            MEASURE: begin
                if (frame_apply) begin
                    if (frame_ok) begin
                        good_cnt_d = good_cnt_q + 8'd1;
                        if (good_cnt_q + 8'd1 >= LOCK_CNT) state_d = LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if ((line_edge && !line_ok) || (frame_apply && !frame_ok) || h_missing) begin
                    err_d   = 1'b1;
                    state_d = SEARCH;
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        in_window = (h_cnt_d >= H_ACT_LO) && (h_cnt_d <= H_ACT_HI) &&
                    (v_cnt_d >= V_ACT_LO) && (v_cnt_d <= V_ACT_HI);
        valid_d   = in_window && (state_d == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q         <= '0;
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            vs_pend_q     <= 1'b0;
            lines_bad_q   <= 1'b0;
            good_cnt_q    <= '0;
            state_q       <= SEARCH;
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            pixel_rgb_q   <= '0;
            pixel_valid_q <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            line_len_q    <= '0;
            sync_error_q  <= 1'b0;
        end else begin
            rgb_q         <= {red, green, blue};
            h_cnt_q       <= h_cnt_d;
            v_cnt_q       <= v_cnt_d;
            vs_pend_q     <= vs_pend_d;
            lines_bad_q   <= lines_bad_d;
            good_cnt_q    <= good_cnt_d;
            state_q       <= state_d;
            pixel_valid_q <= valid_d;
            frame_start_q <= valid_d && (h_cnt_d == H_ACT_LO) && (v_cnt_d == V_ACT_LO);
            locked_q      <= (state_d == LOCKED);
            sync_error_q  <= err_d;
            if (line_edge) line_len_q <= h_meas;
            if (valid_d) begin
                pixel_x_q   <= h_cnt_d - H_ACT_LO;
                pixel_y_q   <= v_cnt_d - V_ACT_LO;
                pixel_rgb_q <= rgb_q;
            end
        end
    end

    assign pixel_x     = pixel_x_q;
    assign pixel_y     = pixel_y_q;
    assign pixel_rgb   = pixel_rgb_q;
    assign pixel_valid = pixel_valid_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign line_len    = line_len_q;
    assign sync_error  = sync_error_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled 20x10 raster
// (active 8x4 at h 8..15, lines 3..6).
module tb_vga_sync_decoder;

    localparam int BH = 4;
    localparam int CH = 4;
    localparam int DH = 8;
    localparam int TH = 20;
    localparam int HT = 2;
    localparam int BV = 1;
    localparam int CV = 2;
    localparam int DV = 4;
    localparam int TV = 10;
    localparam int VT = 1;
    localparam int LF = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        h_sync, v_sync;
    logic [7:0]  red, green, blue;
    logic [10:0] pixel_x, pixel_y, line_len;
    logic [23:0] pixel_rgb;
    logic        pixel_valid, frame_start, locked, sync_error;

    vga_sync_decoder #(
        .BH_TIME(BH), .CH_TIME(CH), .DH_TIME(DH), .TOTAL_H(TH), .H_TOL(HT),
        .BV_TIME(BV), .CV_TIME(CV), .DV_TIME(DV), .TOTAL_V(TV), .V_TOL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_sync     (h_sync),
        .v_sync     (v_sync),
        .red        (red),
        .green      (green),
        .blue       (blue),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pixel_rgb  (pixel_rgb),
        .pixel_valid(pixel_valid),
        .frame_start(frame_start),
        .locked     (locked),
        .line_len   (line_len),
        .sync_error (sync_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [23:0] pat(input int h, input int l);
        if (h == BH + CH && l == BV + CV) return 24'hFF0000;
        return {8'(h), 8'(l), 8'h3C};
    endfunction

    // Stream monitor: tallies what the decoder emits, compared later.
    int   valid_cnt = 0, pix_bad = 0, fs_cnt = 0, fs_bad = 0, fs_cyc = -1;
    int   err_cnt = 0, err_cyc = -1, err_bad = 0, lock_cyc = -1;
    logic [10:0] fs_x = '0, fs_y = '0;
    logic [23:0] fs_rgb = '0;
    logic err_prev = 1'b0, lock_prev = 1'b0;

    always @(negedge clk) begin
        if (pixel_valid === 1'b1) begin
            valid_cnt <= valid_cnt + 1;
            if (pixel_rgb !== pat(int'(pixel_x) + BH + CH, int'(pixel_y) + BV + CV) ||
                pixel_x >= 11'(DH) || pixel_y >= 11'(DV) || locked !== 1'b1)
                pix_bad <= pix_bad + 1;
        end
        if (frame_start === 1'b1) begin
            fs_cnt <= fs_cnt + 1;
            fs_cyc <= cyc;
            fs_x   <= pixel_x;
            fs_y   <= pixel_y;
            fs_rgb <= pixel_rgb;
            if (pixel_valid !== 1'b1 || pixel_x !== 11'd0 || pixel_y !== 11'd0)
                fs_bad <= fs_bad + 1;
        end
        if (sync_error === 1'b1) begin
            err_cnt <= err_cnt + 1;
            err_cyc <= cyc;
            if (locked !== 1'b0 || pixel_valid !== 1'b0 || err_prev)
                err_bad <= err_bad + 1;
        end
        err_prev  <= (sync_error === 1'b1);
        lock_prev <= (locked === 1'b1);
        if (locked === 1'b1 && !lock_prev) lock_cyc <= cyc;
    end

    int n_checks = 0;
    int n_fail   = 0;
    int frame_cyc = 0, pix00_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_line(input int len, input int l);
        for (int h = 0; h < len; h++) begin
            @(negedge clk);
            if (h == 0 && l == 0) frame_cyc = cyc;
            if (h == BH + CH && l == BV + CV) pix00_cyc = cyc;
            h_sync = (h < BH) ? 1'b0 : 1'b1;
            v_sync = (l < BV) ? 1'b0 : 1'b1;
            {red, green, blue} = pat(h, l);
        end
    endtask

    task automatic drive_frame(input int hlen, input int first_line, input int last_line,
                               input int bad_line, input int bad_len);
        for (int l = first_line; l <= last_line; l++)
            drive_line((l == bad_line) ? bad_len : hlen, l);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_x"},     64'(pixel_x),     64'd0);
        check({tag, "_y"},     64'(pixel_y),     64'd0);
        check({tag, "_rgb"},   64'(pixel_rgb),   64'd0);
        check({tag, "_valid"}, 64'(pixel_valid), 64'd0);
        check({tag, "_fs"},    64'(frame_start), 64'd0);
        check({tag, "_lock"},  64'(locked),      64'd0);
        check({tag, "_len"},   64'(line_len),    64'd0);
        check({tag, "_err"},   64'(sync_error),  64'd0);
    endtask

    initial begin
        int f3, g, c, z, w;
        reset  = 1'b1;
        h_sync = 1'b1;
        v_sync = 1'b1;
        red    = '0;
        green  = '0;
        blue   = '0;

        repeat (3) @(negedge clk);
        #1 check_outputs_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Three nominal frames: lock at start of frame 3, one full frame of pixels.
        drive_frame(TH, 0, TV - 1, -1, 0);
        drive_frame(TH, 0, TV - 1, -1, 0);
        drive_frame(TH, 0, TV - 1, -1, 0);
        f3 = frame_cyc;
        #1;
        check("lock_time",   64'(lock_cyc),  64'(f3 + 2));
        check("valid_f3",    64'(valid_cnt), 64'(DH * DV));
        check("fs_count_f3", 64'(fs_cnt),    64'd1);
        check("fs_latency",  64'(fs_cyc),    64'(pix00_cyc + 2));
        check("fs_rgb",      64'(fs_rgb),    64'hFF0000);
        check("fs_x",        64'(fs_x),      64'd0);
        check("fs_y",        64'(fs_y),      64'd0);
        check("pix_model",   64'(pix_bad),   64'd0);
        check("line_len_20", 64'(line_len),  64'd20);
        check("locked_f3",   64'(locked),    64'd1);
        check("no_err_f3",   64'(err_cnt),   64'd0);

        // Line 5 shortened to 17 cycles (just outside tolerance).
        drive_frame(TH, 0, TV - 1, 5, 17);
        g = frame_cyc;
        #1;
        check("short_err_cnt",  64'(err_cnt),   64'd1);
        check("short_err_time", 64'(err_cyc),   64'(g + 5 * TH + 17 + 2));
        check("short_err_form", 64'(err_bad),   64'd0);
        check("short_unlocked", 64'(locked),    64'd0);
        check("short_valid",    64'(valid_cnt), 64'(DH * DV + 3 * DH));

        drive_frame(TH, 0, TV - 1, -1, 0);
        drive_frame(TH, 0, TV - 1, -1, 0);
        #1 check("no_lock_after_2", 64'(locked), 64'd0);
        drive_frame(TH, 0, TV - 1, -1, 0);
        c = frame_cyc;
        #1;
        check("relock_time",  64'(lock_cyc),  64'(c + 2));
        check("relock_valid", 64'(valid_cnt), 64'(2 * DH * DV + 3 * DH));
        check("relock_fs",    64'(fs_cnt),    64'd3);

        // Reset in the middle of a locked frame.
        drive_frame(TH, 0, 4, -1, 0);
        #1 check("pre_reset_locked", 64'(locked), 64'd1);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        #1 check_outputs_zero("midreset");
        reset = 1'b0;
        drive_frame(TH, 5, TV - 1, -1, 0);

        // Off-nominal but in-tolerance raster: 21-cycle lines, 11 lines.
        drive_frame(TH + 1, 0, TV, -1, 0);
        drive_frame(TH + 1, 0, TV, -1, 0);
        #1 check("tol_no_early_lock", 64'(locked), 64'd0);
        drive_frame(TH + 1, 0, TV, -1, 0);
        z = frame_cyc;
        #1;
        check("tol_lock_time", 64'(lock_cyc),  64'(z + 2));
        check("tol_line_len",  64'(line_len),  64'd21);
        check("tol_valid",     64'(valid_cnt), 64'(3 * DH * DV + 5 * DH));
        check("tol_fs",        64'(fs_cnt),    64'd5);

        // h_sync stays high after line 2 starts: missing-edge detection.
        drive_frame(TH + 1, 0, 1, -1, 0);
        w = frame_cyc;
        drive_line(60, 2);
        #1;
        check("miss_err_cnt",  64'(err_cnt),   64'd2);
        check("miss_err_time", 64'(err_cyc),   64'(w + 2 * (TH + 1) + (TH + HT + 1) + 2));
        check("miss_err_form", 64'(err_bad),   64'd0);
        check("miss_unlocked", 64'(locked),    64'd0);
        check("miss_no_valid", 64'(valid_cnt), 64'(3 * DH * DV + 5 * DH));
        check("pix_model_end", 64'(pix_bad),   64'd0);
        check("fs_form_end",   64'(fs_bad),    64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
